// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RV32I-subset processor:
// opcode/funct constants, control enums and the immediate/ALU helpers.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU,
        RES_MEM,
        RES_PC4
    } result_src_t;

    // Sign-extended immediate; the opcode field is not needed so only bits 31:7 come in.
    function automatic logic [XLEN-1:0] imm_extend(input logic [31:7] ins, input imm_src_t src);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (src)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic [XLEN-1:0] alu_compute(input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b,
                                                    input alu_ctrl_t ctrl);
        logic [XLEN-1:0] y;
        y = '0;
        case (ctrl)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/riscv_dmem.sv
// Data memory. Ports: clk, we (write on rising edge), addr (byte address),
// wd (write data), rd (read data, combinational). Low two address bits are
// ignored and the word index wraps modulo the depth.
module riscv_dmem #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   data_memory [WORDS];
    logic [AW-1:0] word_idx;
    logic          unused_addr;

    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign word_idx    = addr[AW+1:2];
    assign rd          = data_memory[word_idx];

    always_ff @(posedge clk) begin
        if (we) begin
            data_memory[word_idx] <= wd;
        end
    end

endmodule

// File: rtl/riscv_imem.sv
// Instruction memory, contents loaded from outside. Ports: addr (byte
// address), rd (instruction word, combinational). Low two address bits are
// ignored and the word index wraps modulo the depth.
module riscv_imem #(
    parameter int WORDS = 64
) (
    input  logic [31:0] addr,
    output logic [31:0] rd
);

    localparam int AW = $clog2(WORDS);

    logic [31:0] instruction_memory [WORDS];
    logic        unused_addr;

    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign rd = instruction_memory[addr[AW+1:2]];

endmodule

// File: rtl/riscv_regfile.sv
// 32 x 32 register file. Ports: clk, we (write enable), a1/a2 (read
// addresses, combinational), a3/wd (write address/data, rising edge),
// rd1/rd2 (read data). x0 always reads zero and is never written.
module riscv_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] registers [32];
    logic [4:0]  raddr [2];
    logic [31:0] rdata [2];

    assign raddr[0] = a1;
    assign raddr[1] = a2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            assign rdata[gi] = (raddr[gi] == 5'd0) ? 32'd0 : registers[raddr[gi]];
        end
    endgenerate

    assign rd1 = rdata[0];
    assign rd2 = rdata[1];

    always_ff @(posedge clk) begin
        if (we && (a3 != 5'd0)) begin
            registers[a3] <= wd;
        end
    end

endmodule

// File: rtl/riscv_single_controller.sv
// Instruction decoder. Inputs: opcode, funct3, funct7 and the ALU zero flag.
// Outputs: register/memory write enables, operand/immediate/result selects,
// ALU operation and the PC-redirect select. Anything not recognised decodes
// to a NOP: no writes and a plain PC+4.
module riscv_single_controller
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        zero,
    output logic        reg_write,
    output logic        mem_write,
    output logic        alu_src,
    output logic        pc_src,
    output imm_src_t    imm_src,
    output alu_ctrl_t   alu_ctrl,
    output result_src_t result_src
);

    logic branch;
    logic jump;

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        imm_src    = IMM_I;
        alu_ctrl   = ALU_ADD;
        result_src = RES_ALU;
        branch     = 1'b0;
        jump       = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD: begin reg_write = 1'b1; alu_ctrl = ALU_ADD; end
                        F3_AND: begin reg_write = 1'b1; alu_ctrl = ALU_AND; end
                        F3_OR:  begin reg_write = 1'b1; alu_ctrl = ALU_OR;  end
                        F3_SLT: begin reg_write = 1'b1; alu_ctrl = ALU_SLT; end
                        default: ;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    reg_write = 1'b1;
                    alu_ctrl  = ALU_SUB;
                end
            end
            OP_I_ALU: begin
                case (funct3)
                    F3_ADD: begin reg_write = 1'b1; alu_src = 1'b1; alu_ctrl = ALU_ADD; end
                    F3_AND: begin reg_write = 1'b1; alu_src = 1'b1; alu_ctrl = ALU_AND; end
                    F3_OR:  begin reg_write = 1'b1; alu_src = 1'b1; alu_ctrl = ALU_OR;  end
                    F3_SLT: begin reg_write = 1'b1; alu_src = 1'b1; alu_ctrl = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_LOAD: begin
                if (funct3 == F3_WORD) begin
                    reg_write  = 1'b1;
                    alu_src    = 1'b1;
                    result_src = RES_MEM;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_WORD) begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                    imm_src   = IMM_S;
                end
            end
            OP_BRANCH: begin
                // beq compares by subtracting and testing the zero flag
                if (funct3 == F3_BEQ) begin
                    branch   = 1'b1;
                    alu_ctrl = ALU_SUB;
                    imm_src  = IMM_B;
                end
            end
            OP_JAL: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                imm_src    = IMM_J;
                result_src = RES_PC4;
            end
            default: ;
        endcase
    end

    assign pc_src = (branch && zero) || jump;

endmodule

// File: rtl/riscv_single_core.sv
// Single-cycle core: controller plus datapath. Inputs: clk, reset,
// fetched instruction, data-memory read data. Outputs: pc (fetch address),
// data_addr, write_data and mem_write toward data memory. Architectural
// writes are suppressed on any edge where reset is high.
module riscv_single_core
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] read_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] data_addr,
    output logic [XLEN-1:0] write_data,
    output logic            mem_write
);

    logic        reg_write;
    logic        mem_write_dec;
    logic        alu_src;
    logic        pc_src;
    logic        zero;
    imm_src_t    imm_src;
    alu_ctrl_t   alu_ctrl;
    result_src_t result_src;

    riscv_single_controller Controller_instance (
        .opcode     (instr[6:0]),
        .funct3     (instr[14:12]),
        .funct7     (instr[31:25]),
        .zero       (zero),
        .reg_write  (reg_write),
        .mem_write  (mem_write_dec),
        .alu_src    (alu_src),
        .pc_src     (pc_src),
        .imm_src    (imm_src),
        .alu_ctrl   (alu_ctrl),
        .result_src (result_src)
    );

    riscv_single_datapath DataPath_instance (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write && !reset),
        .alu_src    (alu_src),
        .pc_src     (pc_src),
        .imm_src    (imm_src),
        .alu_ctrl   (alu_ctrl),
        .result_src (result_src),
        .instr      (instr),
        .read_data  (read_data),
        .pc         (pc),
        .alu_result (data_addr),
        .write_data (write_data),
        .zero       (zero)
    );

    assign mem_write = mem_write_dec && !reset;

endmodule

// File: rtl/riscv_single_datapath.sv
// Datapath: PC register, register file, immediate generation, ALU and
// result mux. Inputs: clk, reset, decoded control, instruction and memory
// read data. Outputs: pc, alu_result (also the data address), write_data
// (store data) and the ALU zero flag. Reset clears only the PC.
module riscv_single_datapath
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             reg_write,
    input  logic             alu_src,
    input  logic             pc_src,
    input  imm_src_t         imm_src,
    input  alu_ctrl_t        alu_ctrl,
    input  result_src_t      result_src,
    input  logic [XLEN-1:0]  instr,
    input  logic [XLEN-1:0]  read_data,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  alu_result,
    output logic [XLEN-1:0]  write_data,
    output logic             zero
);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] result;
    logic            unused_opcode;

    // The opcode field is consumed by the controller only.
    assign unused_opcode = ^instr[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc        = pc_reg;
    assign pc_plus4  = pc_reg + 32'd4;
    assign pc_target = pc_reg + imm_ext;
    assign pc_next   = pc_src ? pc_target : pc_plus4;

    assign imm_ext = imm_extend(instr[31:7], imm_src);

    riscv_regfile RegisterFile (
        .clk (clk),
        .we  (reg_write),
        .a1  (instr[19:15]),
        .a2  (instr[24:20]),
        .a3  (instr[11:7]),
        .wd  (result),
        .rd1 (src_a),
        .rd2 (write_data)
    );

    assign src_b      = alu_src ? imm_ext : write_data;
    assign alu_result = alu_compute(src_a, src_b, alu_ctrl);
    assign zero       = (alu_result == '0);

    always_comb begin
        result = alu_result;
        case (result_src)
            RES_MEM: result = read_data;
            RES_PC4: result = pc_plus4;
            default: result = alu_result;
        endcase
    end

endmodule

// File: rtl/riscv_single_top.sv
// Top level of the single-cycle RV32I-subset processor. Ports: clk, reset
// (synchronous, active high). Program, data and register contents are
// loaded and inspected through the hierarchy; there is no other I/O.
module riscv_single_top #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic clk,
    input  logic reset
);

    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_write;

    riscv_single_core RISCVSingle (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .read_data  (read_data),
        .pc         (pc),
        .data_addr  (data_addr),
        .write_data (write_data),
        .mem_write  (mem_write)
    );

    riscv_imem #(.WORDS(IMEM_WORDS)) InstructionMemory (
        .addr (pc),
        .rd   (instr)
    );

    riscv_dmem #(.WORDS(DMEM_WORDS)) DataMemory (
        .clk  (clk),
        .we   (mem_write),
        .addr (data_addr),
        .wd   (write_data),
        .rd   (read_data)
    );

endmodule

// File: tb/tb_riscv_single_top.sv
module tb_riscv_single_top;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    riscv_single_top #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } state_vec_t;

    state_vec_t  final_tbl [$];
    logic [31:0] prog [$];
    logic [31:0] pc_trace [$];

    function automatic logic [31:0] reg_val(input int i);
        return dut.RISCVSingle.DataPath_instance.RegisterFile.registers[i];
    endfunction

    function automatic logic [31:0] mem_val(input int i);
        return dut.DataMemory.data_memory[i];
    endfunction

    function automatic logic [31:0] pc_val();
        return dut.RISCVSingle.DataPath_instance.pc_reg;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_state(input string name, input bit is_mem, input int idx, input logic [31:0] exp);
        state_vec_t v;
        v.name = name; v.is_mem = is_mem; v.idx = idx; v.exp = exp;
        final_tbl.push_back(v);
    endtask

    task automatic check_final_state(input string tag);
        int bad;
        foreach (final_tbl[k]) begin
            if (final_tbl[k].is_mem)
                check({tag, "_", final_tbl[k].name}, mem_val(final_tbl[k].idx), final_tbl[k].exp);
            else
                check({tag, "_", final_tbl[k].name}, reg_val(final_tbl[k].idx), final_tbl[k].exp);
        end
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (i != 2 && mem_val(i) !== (32'hA500_0000 + 32'(i))) bad++;
        check({tag, "_dmem_untouched_mismatches"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int bad;

        prog = '{32'h00500093,   // 00 addi x1,x0,5
                 32'hFFD00113,   // 04 addi x2,x0,-3
                 32'h002081B3,   // 08 add  x3,x1,x2
                 32'h40208233,   // 0C sub  x4,x1,x2
                 32'h001122B3,   // 10 slt  x5,x2,x1
                 32'h0020F333,   // 14 and  x6,x1,x2
                 32'h0020E3B3,   // 18 or   x7,x1,x2
                 32'h00302423,   // 1C sw   x3,8(x0)
                 32'h008004EF,   // 20 jal  x9,+8
                 32'h00100593,   // 24 addi x11,x0,1 (skipped)
                 32'h00802403,   // 28 lw   x8,8(x0)
                 32'h00108463,   // 2C beq  x1,x1,+8
                 32'h00100613,   // 30 addi x12,x0,1 (skipped)
                 32'h00208463,   // 34 beq  x1,x2,+8 (not taken)
                 32'h00300693,   // 38 addi x13,x0,3
                 32'h00700013,   // 3C addi x0,x0,7
                 32'h00000533,   // 40 add  x10,x0,x0
                 32'h0020C733,   // 44 xor  x14,x1,x2 (unsupported -> NOP)
                 32'h0000006F};  // 48 jal  x0,0

        pc_trace = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
                     32'h28, 32'h2C, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h48,
                     32'h48, 32'h48, 32'h48, 32'h48};

        add_state("x0",  0, 0,  32'h0000_0000);
        add_state("x1",  0, 1,  32'h0000_0005);
        add_state("x2",  0, 2,  32'hFFFF_FFFD);
        add_state("x3",  0, 3,  32'h0000_0002);
        add_state("x4",  0, 4,  32'h0000_0008);
        add_state("x5",  0, 5,  32'h0000_0001);
        add_state("x6",  0, 6,  32'h0000_0005);
        add_state("x7",  0, 7,  32'hFFFF_FFFD);
        add_state("x8",  0, 8,  32'h0000_0002);
        add_state("x9",  0, 9,  32'h0000_0024);
        add_state("x10", 0, 10, 32'h0000_0000);
        add_state("x11", 0, 11, 32'hDEAD_000B);
        add_state("x12", 0, 12, 32'hDEAD_000C);
        add_state("x13", 0, 13, 32'h0000_0003);
        add_state("x14", 0, 14, 32'hDEAD_000E);
        add_state("x15", 0, 15, 32'hDEAD_000F);
        add_state("mem2", 1, 2, 32'h0000_0002);

        // Backdoor load while reset holds the core
        for (int i = 0; i < 64; i++)
            dut.InstructionMemory.instruction_memory[i] = (i < prog.size()) ? prog[i] : 32'h0;
        for (int i = 0; i < 32; i++)
            dut.RISCVSingle.DataPath_instance.RegisterFile.registers[i] = (i == 0) ? 32'h0 : (32'hDEAD_0000 + 32'(i));
        for (int i = 0; i < 64; i++)
            dut.DataMemory.data_memory[i] = 32'hA500_0000 + 32'(i);

        // Reset held for 8 cycles
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("reset_pc_c%0d", c), pc_val(), 32'h0);
        end
        bad = 0;
        for (int i = 1; i < 32; i++)
            if (reg_val(i) !== (32'hDEAD_0000 + 32'(i))) bad++;
        check("reset_regs_mismatches", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (mem_val(i) !== (32'hA500_0000 + 32'(i))) bad++;
        check("reset_dmem_mismatches", 32'(bad), 32'd0);

        // Program run, PC checked after every edge
        reset = 1'b0;
        foreach (pc_trace[k]) begin
            step();
            check($sformatf("run_pc_%0d", k), pc_val(), pc_trace[k]);
        end
        check_final_state("run1");

        // Mid-run reset: clobber some state, restart, pulse reset at PC=0x10
        for (int i = 1; i <= 4; i++)
            dut.RISCVSingle.DataPath_instance.RegisterFile.registers[i] = 32'h0;
        dut.RISCVSingle.DataPath_instance.RegisterFile.registers[5] = 32'h5555_5555;
        dut.RISCVSingle.DataPath_instance.RegisterFile.registers[9] = 32'h0;
        dut.DataMemory.data_memory[2] = 32'h2222_2222;

        reset = 1'b1;
        step();
        check("restart_pc", pc_val(), 32'h0);
        reset = 1'b0;
        repeat (4) step();
        check("pre_midreset_pc", pc_val(), 32'h10);
        reset = 1'b1;
        step();
        check("midreset_pc", pc_val(), 32'h0);
        check("midreset_x1", reg_val(1), 32'h0000_0005);
        check("midreset_x2", reg_val(2), 32'hFFFF_FFFD);
        check("midreset_x3", reg_val(3), 32'h0000_0002);
        check("midreset_x4", reg_val(4), 32'h0000_0008);
        check("midreset_x5_no_write", reg_val(5), 32'h5555_5555);
        check("midreset_mem2", mem_val(2), 32'h2222_2222);
        reset = 1'b0;
        repeat (60) step();
        check("run2_pc", pc_val(), 32'h48);
        check_final_state("run2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
